stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DB_SAMPLES, default 3: number of consecutive equal tick_db samples required to change a debounced button level (range 2-8).
REQ-002 SHALL have port clk, input, 1: 100 MHz system clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port tick_1k, input, 1: one-clk enable pulse at 1 kHz (timing base).
REQ-005 SHALL have port tick_db, input, 1: one-clk enable pulse at 100 Hz (debounce sample strobe).
REQ-006 SHALL have ports btn_start, btn_lap and btn_clr, input, 1 each: raw asynchronous push-buttons, active-high.
REQ-007 SHALL have port time_bcd, output, 28: {min_t, min_u, sec_t, sec_u, ms_h, ms_t, ms_u}, 4-bit BCD each, value to display.
REQ-008 SHALL have port state, output, 2: 0 IDLE, 1 RUN, 2 LAP, 3 PAUSE.
REQ-009 SHALL have port ovf, output, 1: set when count saturated at 59:59.999.

Function
REQ-010 SHALL synchronise each raw button through 2 flip-flops before any use.
REQ-011 SHALL sample each synchronised button only in cycles with tick_db=1; debounced level SHALL flip only when the last DB_SAMPLES samples are all equal and differ from the current level.
REQ-012 SHALL generate a one-clk press pulse on each debounced 0->1 transition; 1->0 generates nothing.
REQ-013 SHALL hold an internal live counter: ms 0-999, sec 0-59, min 0-59, all BCD, each digit wrapping 9->0 with carry; sec_t wraps 5->0 into min, min_t wraps 5->0 only via saturation (REQ-016).
REQ-014 SHALL increment the live counter by 1 ms in each cycle where tick_1k=1 and the current state register is RUN or LAP; transitions in the same cycle do not affect that decision.
REQ-015 FSM transitions on press pulses: IDLE -start-> RUN; RUN -start-> PAUSE, -lap-> LAP; LAP -lap-> RUN, -start-> PAUSE; PAUSE -start-> RUN, -clr-> IDLE; all other press/state combinations ignored.
REQ-016 SHALL, when a tick would advance the count past 59:59.999, keep it at 59:59.999, set ovf=1 and enter PAUSE next cycle.
REQ-017 SHALL, on PAUSE -clr-> IDLE, zero the live counter and frozen register and clear ovf in the same edge.
REQ-018 SHALL copy the live counter into a frozen register on entering LAP; time_bcd SHALL show frozen register in LAP and live counter in IDLE, RUN and PAUSE.
REQ-019 Simultaneous presses in one cycle: priority clr > start > lap; only the highest-priority press valid for the current state is acted on, the rest discarded.
REQ-020 SHALL register all outputs; time_bcd and state change one clk after the causing edge.
REQ-021 Latency from raw press to state change: 2 clk sync + DB_SAMPLES tick_db strobes + 2 clk.

Reset
REQ-022 SHALL on rst=1 immediately force: state IDLE, live and frozen counters 0, time_bcd 0, ovf 0, sync flops, sample histories and debounced levels 0, no press pulses.
REQ-023 SHALL resume normal operation on the first clk edge after rst deasserts; button already held high at release SHALL be reported as one press after debouncing.

Verification
REQ-024 Hold btn_start high, 5 tick_db strobes -> exactly one press, state IDLE->RUN; 1000 tick_1k -> time_bcd = 00:01.000 (0x0001000).
REQ-025 btn_start toggled on each of 2 tick_db samples then released (bounce shorter than DB_SAMPLES) -> no press, state unchanged.
REQ-026 RUN at 00:00.500, lap press, 300 tick_1k -> time_bcd stays 0x0000500; lap press -> time_bcd 0x0000800.
REQ-027 Preload 59:59.998 in RUN, 3 tick_1k -> time_bcd 0x5959999, ovf=1, state PAUSE; clr press -> time_bcd 0, ovf 0, IDLE.
REQ-028 In RUN, start and clr pulses in same cycle -> PAUSE (clr invalid in RUN); in PAUSE, both -> IDLE.
REQ-029 Assert rst during RUN at 00:12.345 -> outputs 0 and IDLE without clk edge; tick_1k ignored until start press.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button sync/debounce, BCD mm:ss.mmm counter,
// lap freeze, saturation. Ports: clk, rst, tick_1k, tick_db, btn_*,
// time_bcd, state, ovf.
module stopwatch_ctrl #(
  parameter int DB_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1k,
  input  logic        tick_db,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic [27:0] time_bcd,
  output logic [1:0]  state,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [27:0] LIVE_MAX = 28'h5959999;

  state_t      st_q;
  logic [27:0] live_q;
  logic [27:0] frozen_q;
  logic [2:0]  raw;
  logic [2:0]  s1_q;
  logic [2:0]  s2_q;
  logic [2:0]  lvl_q;
  logic [2:0]  press_q;
  logic [DB_SAMPLES-1:0] hist_q [3];
  logic [DB_SAMPLES-1:0] hist_n [3];
  logic tick_en;
  logic sat;
  logic p_start;
  logic p_lap;
  logic p_clr;

  assign raw     = {btn_clr, btn_lap, btn_start};
  assign p_start = press_q[0];
  assign p_lap   = press_q[1];
  assign p_clr   = press_q[2];
  assign tick_en = tick_1k & ((st_q == S_RUN) | (st_q == S_LAP));
  assign sat     = tick_en & (live_q == LIVE_MAX);
  assign state   = st_q;

  // Sample history including the sample taken this strobe.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hist_n[i] = {hist_q[i][DB_SAMPLES-2:0], s2_q[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      press_q <= '0;
      if (tick_db) begin
        for (int i = 0; i < 3; i++) begin
          hist_q[i] <= hist_n[i];
          if ((&hist_n[i]) && !lvl_q[i]) begin
            lvl_q[i]   <= 1'b1;
            press_q[i] <= 1'b1;
          end else if (!(|hist_n[i]) && lvl_q[i]) begin
            lvl_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // BCD +1 ms; min_t never wraps because MAX saturates first.
  function automatic logic [27:0] bcd_inc(input logic [27:0] v);
    logic [27:0] r;
    logic [3:0]  lim;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 7; d++) begin
      lim = ((d == 4) || (d == 6)) ? 4'd5 : 4'd9;
      if (c) begin
        if (r[d*4 +: 4] == lim) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      live_q   <= '0;
      frozen_q <= '0;
      time_bcd <= '0;
      ovf      <= 1'b0;
    end else begin
      time_bcd <= (st_q == S_LAP) ? frozen_q : live_q;
      if (tick_en) begin
        if (sat) ovf <= 1'b1;
        else     live_q <= bcd_inc(live_q);
      end
      // Priority clr > start > lap among presses valid here.
      unique case (st_q)
        S_IDLE: begin
          if (p_start) st_q <= S_RUN;
        end
        S_RUN: begin
          if (p_start) begin
            st_q <= S_PAUSE;
          end else if (p_lap) begin
            st_q     <= S_LAP;
            frozen_q <= live_q;
          end
        end
        S_LAP: begin
          if (p_start)    st_q <= S_PAUSE;
          else if (p_lap) st_q <= S_RUN;
        end
        S_PAUSE: begin
          if (p_clr) begin
            st_q     <= S_IDLE;
            live_q   <= '0;
            frozen_q <= '0;
            ovf      <= 1'b0;
          end else if (p_start) begin
            st_q <= S_RUN;
          end
        end
        default: st_q <= S_IDLE;
      endcase
      // Saturation overrides any press this cycle.
      if (sat) st_q <= S_PAUSE;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios plus randomized
// button/tick traffic against a millisecond-count reference model.
module tb_stopwatch_ctrl;
  localparam int DB = 3;
  localparam int MAXMS = 3599999;

  logic        clk;
  logic        rst;
  logic        tick_1k;
  logic        tick_db;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clr;
  logic [27:0] time_bcd;
  logic [1:0]  state;
  logic        ovf;

  int n_checks;
  int n_fail;

  // reference model
  int       m_t;
  int       m_fz;
  int       m_st;
  bit       m_ovf;
  bit       m_lvl [3];
  bit       m_last [3];
  int       m_run [3];
  bit [2:0] btn;

  stopwatch_ctrl #(.DB_SAMPLES(DB)) dut (
    .clk(clk), .rst(rst), .tick_1k(tick_1k), .tick_db(tick_db),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .time_bcd(time_bcd), .state(state), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] to_bcd(input int t);
    int mn, sc, ms;
    mn = t / 60000;
    sc = (t / 1000) % 60;
    ms = t % 1000;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10),
            4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  function automatic logic [27:0] exp_disp();
    return to_bcd(m_st == 2 ? m_fz : m_t);
  endfunction

  function automatic void model_reset();
    m_t = 0; m_fz = 0; m_st = 0; m_ovf = 0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 0; m_last[i] = 0; m_run[i] = DB;
    end
  endfunction

  function automatic void model_press(bit s, bit l, bit c);
    case (m_st)
      0: if (s) m_st = 1;
      1: if (s) m_st = 3;
         else if (l) begin m_fz = m_t; m_st = 2; end
      2: if (s) m_st = 3;
         else if (l) m_st = 1;
      3: if (c) begin m_t = 0; m_fz = 0; m_ovf = 0; m_st = 0; end
         else if (s) m_st = 1;
      default: ;
    endcase
  endfunction

  function automatic void model_strobe();
    bit pr [3];
    for (int i = 0; i < 3; i++) begin
      pr[i] = 0;
      if (btn[i] == m_last[i]) m_run[i]++;
      else begin m_run[i] = 1; m_last[i] = btn[i]; end
      if (m_run[i] >= DB && btn[i] != m_lvl[i]) begin
        m_lvl[i] = btn[i];
        pr[i] = btn[i];
      end
    end
    model_press(pr[0], pr[1], pr[2]);
  endfunction

  function automatic void model_tick();
    if (m_st == 1 || m_st == 2) begin
      if (m_t == MAXMS) begin m_ovf = 1; m_st = 3; end
      else m_t++;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input bit s, input bit l, input bit c);
    btn = {c, l, s};
    btn_start = s; btn_lap = l; btn_clr = c;
    idle(3);
  endtask

  task automatic strobe();
    tick_db = 1'b1;
    @(negedge clk);
    tick_db = 1'b0;
    model_strobe();
    idle(4);
  endtask

  task automatic ms_ticks(input int n);
    tick_1k = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_tick();
      @(negedge clk);
    end
    tick_1k = 1'b0;
    idle(3);
  endtask

  task automatic press(input bit s, input bit l, input bit c);
    set_btns(s, l, c);
    repeat (DB) strobe();
    set_btns(0, 0, 0);
    repeat (DB) strobe();
  endtask

  task automatic preload(input int t);
    logic [27:0] v;
    v = to_bcd(t);
    m_t = t;
    force dut.live_q = v;
    #1;
    release dut.live_q;
    @(negedge clk);
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_1k = 0; tick_db = 0;
    btn = '0; btn_start = 0; btn_lap = 0; btn_clr = 0;
    model_reset();
    idle(2);
    n_checks++; if (time_bcd !== 28'h0) begin n_fail++; $display("FAIL reset_time got=%h exp=0", time_bcd); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_start_hold();
    set_btns(1, 0, 0);
    repeat (2) strobe();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL hold_early got=%0d exp=0", state); end
    strobe();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL hold_run got=%0d exp=1", state); end
    repeat (2) strobe();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL hold_single got=%0d exp=1", state); end
    set_btns(0, 0, 0);
    repeat (DB) strobe();
    ms_ticks(1000);
    n_checks++; if (time_bcd !== 28'h0001000) begin n_fail++; $display("FAIL one_sec got=%h exp=0001000", time_bcd); end
  endtask

  task automatic test_bounce();
    set_btns(1, 0, 0);
    strobe();
    set_btns(0, 0, 0);
    strobe();
    set_btns(1, 0, 0);
    strobe();
    set_btns(1, 0, 0);
    strobe();
    set_btns(0, 0, 0);
    repeat (DB) strobe();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL bounce_state got=%0d exp=1", state); end
    n_checks++; if (time_bcd !== 28'h0001000) begin n_fail++; $display("FAIL bounce_time got=%h exp=0001000", time_bcd); end
  endtask

  task automatic test_async_reset();
    ms_ticks(11345);
    n_checks++; if (time_bcd !== 28'h0012345) begin n_fail++; $display("FAIL pre_rst got=%h exp=0012345", time_bcd); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (time_bcd !== 28'h0) begin n_fail++; $display("FAIL async_time got=%h exp=0", time_bcd); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_state got=%0d exp=0", state); end
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    ms_ticks(100);
    n_checks++; if (time_bcd !== 28'h0) begin n_fail++; $display("FAIL idle_tick got=%h exp=0", time_bcd); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_state got=%0d exp=0", state); end
  endtask

  task automatic test_lap();
    press(1, 0, 0);
    ms_ticks(500);
    n_checks++; if (time_bcd !== 28'h0000500) begin n_fail++; $display("FAIL lap_pre got=%h exp=0000500", time_bcd); end
    press(0, 1, 0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL lap_state got=%0d exp=2", state); end
    ms_ticks(300);
    n_checks++; if (time_bcd !== 28'h0000500) begin n_fail++; $display("FAIL lap_frozen got=%h exp=0000500", time_bcd); end
    press(0, 1, 0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL lap_back got=%0d exp=1", state); end
    n_checks++; if (time_bcd !== 28'h0000800) begin n_fail++; $display("FAIL lap_live got=%h exp=0000800", time_bcd); end
  endtask

  task automatic test_overflow();
    preload(3599998);
    ms_ticks(3);
    n_checks++; if (time_bcd !== 28'h5959999) begin n_fail++; $display("FAIL sat_time got=%h exp=5959999", time_bcd); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", ovf); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL sat_state got=%0d exp=3", state); end
    press(0, 0, 1);
    n_checks++; if (time_bcd !== 28'h0) begin n_fail++; $display("FAIL clr_time got=%h exp=0", time_bcd); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL clr_state got=%0d exp=0", state); end
  endtask

  task automatic test_simul();
    press(1, 0, 0);
    ms_ticks(7);
    press(1, 0, 1);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL simul_run got=%0d exp=3", state); end
    press(1, 0, 1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL simul_pause got=%0d exp=0", state); end
    n_checks++; if (time_bcd !== 28'h0) begin n_fail++; $display("FAIL simul_time got=%h exp=0", time_bcd); end
  endtask

  task automatic test_held_at_release();
    btn[0] = 1'b1;
    btn_start = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    repeat (DB - 1) strobe();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_early got=%0d exp=0", state); end
    strobe();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL held_press got=%0d exp=1", state); end
    repeat (3) strobe();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL held_once got=%0d exp=1", state); end
    set_btns(0, 0, 0);
    repeat (DB) strobe();
  endtask

  task automatic test_random();
    int r;
    bit [2:0] nb;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      if (r < 9) begin
        nb = btn;
        for (int i = 0; i < 3; i++) if ($urandom_range(0, 3) == 0) nb[i] = ~nb[i];
        set_btns(nb[0], nb[1], nb[2]);
        strobe();
      end else if (r < 14) begin
        strobe();
      end else if (r < 19) begin
        ms_ticks($urandom_range(1, 200));
      end else if (m_st == 1) begin
        preload(MAXMS - 9 + $urandom_range(0, 9));
      end
      n_checks++; if (state !== 2'(m_st)) begin n_fail++; $display("FAIL rnd_state it=%0d got=%0d exp=%0d", it, state, m_st); end
      n_checks++; if (time_bcd !== exp_disp()) begin n_fail++; $display("FAIL rnd_time it=%0d got=%h exp=%h", it, time_bcd, exp_disp()); end
      n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf it=%0d got=%b exp=%b", it, ovf, m_ovf); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_start_hold();
    test_bounce();
    test_async_reset();
    test_lap();
    test_overflow();
    test_simul();
    test_held_at_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
